// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between the icache fill path and the dcache fill/write-back path.
// Optional ARB_DPRIO_EN: fixed dcache priority on ties instead of round-robin.
module mem_arbiter #(
    parameter int MEM_LAT = 5,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [31:0]        i_addr,
    output logic               i_done,
    output logic [127:0]       i_rdata,
    input  logic               d_req,
    input  logic               d_wr,
    input  logic [31:0]        d_addr,
    input  logic [127:0]       d_wdata,
    output logic               d_done,
    output logic [127:0]       d_rdata,
    output logic [31:0]        addr_mem,
    output logic               rd_mem,
    output logic               wr_mem,
    output logic [127:0]       data_in_mem,
    input  logic [127:0]       data_out_mem,
    output logic               busy,
    output logic [CNT_W-1:0]   i_grants,
    output logic [CNT_W-1:0]   d_grants
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;
    localparam logic [3:0]  LAT_LAST  = 4'(MEM_LAT - 1);
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    logic [1:0] state_r;
    logic [3:0] lat_cnt_r;
    logic       own_d_r;
    logic       wr_r;
    logic       grant_s;
    logic       grant_d_s;
    logic       is_wr_s;

`ifndef ARB_DPRIO_EN
    logic       rr_r;
`endif

    // Arbitration decision for the current IDLE cycle
    always_comb begin
        grant_s   = 1'b0;
        grant_d_s = 1'b0;
        if (i_req || d_req) begin
            grant_s = 1'b1;
`ifdef ARB_DPRIO_EN
            grant_d_s = d_req;
`else
            grant_d_s = d_req && (!i_req || !rr_r);
`endif
        end else begin
            grant_s   = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    assign is_wr_s = grant_d_s && d_wr;

`ifndef ARB_DPRIO_EN
    // Round-robin pointer: favours the requester that did not own the last completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_r <= 1'b0;
        end else if (state_r == ST_ACCESS && lat_cnt_r == LAT_LAST) begin
            rr_r <= own_d_r;
        end
    end
`endif

    // Transaction FSM with registered memory strobes, done pulses and statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lat_cnt_r   <= 4'd0;
            own_d_r     <= 1'b0;
            wr_r        <= 1'b0;
            addr_mem    <= 32'd0;
            data_in_mem <= 128'd0;
            rd_mem      <= 1'b0;
            wr_mem      <= 1'b0;
            busy        <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            i_rdata     <= 128'd0;
            d_rdata     <= 128'd0;
            i_grants    <= {CNT_W{1'b0}};
            d_grants    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    if (grant_s) begin
                        own_d_r     <= grant_d_s;
                        wr_r        <= is_wr_s;
                        addr_mem    <= (grant_d_s ? d_addr : i_addr) & LINE_MASK;
                        data_in_mem <= grant_d_s ? d_wdata : 128'd0;
                        rd_mem      <= !is_wr_s;
                        wr_mem      <= is_wr_s;
                        busy        <= 1'b1;
                        lat_cnt_r   <= 4'd0;
                        state_r     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    lat_cnt_r <= lat_cnt_r + 4'd1;
                    if (lat_cnt_r == LAT_LAST) begin
                        rd_mem  <= 1'b0;
                        wr_mem  <= 1'b0;
                        state_r <= ST_DONE;
                        // Write-backs leave d_rdata untouched
                        if (own_d_r) begin
                            d_done   <= 1'b1;
                            d_grants <= d_grants + CNT_W'(1);
                            if (!wr_r) begin
                                d_rdata <= data_out_mem;
                            end
                        end else begin
                            i_done   <= 1'b1;
                            i_grants <= i_grants + CNT_W'(1);
                            i_rdata  <= data_out_mem;
                        end
                    end
                end
                ST_DONE: begin
                    i_done  <= 1'b0;
                    d_done  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    i_done  <= 1'b0;
                    d_done  <= 1'b0;
                    rd_mem  <= 1'b0;
                    wr_mem  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: MEM_LAT=5 main instance plus a MEM_LAT=1 instance.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req, d_wr;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wdata, data_out_mem;
    logic         i_done, d_done, rd_mem, wr_mem, busy;
    logic [127:0] i_rdata, d_rdata, data_in_mem;
    logic [31:0]  addr_mem;
    logic [11:0]  i_grants, d_grants;

    logic         i_req1, d_req1, d_wr1;
    logic [31:0]  i_addr1, d_addr1;
    logic [127:0] d_wdata1, data_out_mem1;
    logic         i_done1, d_done1, rd_mem1, wr_mem1, busy1;
    logic [127:0] i_rdata1, d_rdata1, data_in_mem1;
    logic [31:0]  addr_mem1;
    logic [11:0]  i_grants1, d_grants1;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(5), .CNT_W(12)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .data_in_mem(data_in_mem), .data_out_mem(data_out_mem),
        .busy(busy), .i_grants(i_grants), .d_grants(d_grants)
    );

    mem_arbiter #(.MEM_LAT(1), .CNT_W(12)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_done(d_done1), .d_rdata(d_rdata1),
        .addr_mem(addr_mem1), .rd_mem(rd_mem1), .wr_mem(wr_mem1),
        .data_in_mem(data_in_mem1), .data_out_mem(data_out_mem1),
        .busy(busy1), .i_grants(i_grants1), .d_grants(d_grants1)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // owner: 0 none (timeout), 1 icache, 2 dcache, 3 both dones together
    task automatic observe(input int max_cyc, output int rd_cnt, output int wr_cnt,
                           output int done_at, output int owner,
                           output logic [31:0] addr_seen, output logic [127:0] din_seen);
        rd_cnt = 0; wr_cnt = 0; done_at = -1; owner = 0;
        addr_seen = 32'd0; din_seen = 128'd0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_mem) rd_cnt++;
            if (wr_mem) begin
                wr_cnt++;
                din_seen = data_in_mem;
            end
            if (rd_mem || wr_mem) addr_seen = addr_mem;
            if (i_done || d_done) begin
                done_at = k;
                owner = (i_done && d_done) ? 3 : (i_done ? 1 : 2);
                break;
            end
        end
    endtask

    int rd_cnt, wr_cnt, done_at, owner, extra, pulses;
    logic [31:0]  addr_seen;
    logic [127:0] din_seen;
    int exp_own [4];

    initial begin
`ifdef ARB_DPRIO_EN
        exp_own = '{2, 2, 2, 2};
`else
        exp_own = '{2, 1, 2, 1};
`endif
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 128'd0; data_out_mem = 128'd0;
        i_req1 = 1'b0; d_req1 = 1'b0; d_wr1 = 1'b0;
        i_addr1 = 32'd0; d_addr1 = 32'd0; d_wdata1 = 128'd0; data_out_mem1 = 128'd0;

        // Reset state
        @(negedge clk);
        check_val("rst_ctrl", {i_done, d_done, rd_mem, wr_mem, busy}, 128'd0);
        check_val("rst_addr", addr_mem, 128'd0);
        check_val("rst_cnt", {i_grants, d_grants}, 128'd0);
        check_val("rst_rdata", i_rdata | d_rdata | data_in_mem, 128'd0);
        rst = 1'b1;
        @(negedge clk);

        // MEM_LAT=1 single icache fill
        i_req1 = 1'b1; i_addr1 = 32'h0000_0100; data_out_mem1 = 128'h77;
        rd_cnt = 0; done_at = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_mem1) rd_cnt++;
            if (i_done1) begin
                done_at = k;
                break;
            end
        end
        i_req1 = 1'b0;
        check_val("lat1_rd_cycles", rd_cnt, 128'd1);
        check_val("lat1_done_at", done_at, 128'd2);
        check_val("lat1_rdata", i_rdata1, 128'h77);

        // Single icache read
        i_req = 1'b1; i_addr = 32'h0000_1234; data_out_mem = {16{8'hA5}};
        observe(12, rd_cnt, wr_cnt, done_at, owner, addr_seen, din_seen);
        i_req = 1'b0;
        check_val("rd_rd_cycles", rd_cnt, 128'd5);
        check_val("rd_wr_cycles", wr_cnt, 128'd0);
        check_val("rd_done_at", done_at, 128'd6);
        check_val("rd_owner", owner, 128'd1);
        check_val("rd_addr", addr_seen, 128'h1230);
        check_val("rd_rdata", i_rdata, {16{8'hA5}});
        check_val("rd_igrants", i_grants, 128'd1);
        check_val("rd_busy_done", busy, 128'd1);
        @(negedge clk);
        check_val("rd_idle", {busy, i_done, d_done}, 128'd0);

        // dcache write-back
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0040; d_wdata = 128'h1;
        data_out_mem = 128'hDEAD_BEEF;
        observe(12, rd_cnt, wr_cnt, done_at, owner, addr_seen, din_seen);
        d_req = 1'b0; d_wr = 1'b0;
        check_val("wb_wr_cycles", wr_cnt, 128'd5);
        check_val("wb_rd_cycles", rd_cnt, 128'd0);
        check_val("wb_din", din_seen, 128'h1);
        check_val("wb_owner", owner, 128'd2);
        check_val("wb_addr", addr_seen, 128'h40);
        check_val("wb_drdata", d_rdata, 128'd0);
        check_val("wb_dgrants", d_grants, 128'd1);
        @(negedge clk);

        // Contention from reset
        rst = 1'b0;
        @(negedge clk);
        check_val("rst2_cnt", {i_grants, d_grants}, 128'd0);
        rst = 1'b1;
        data_out_mem = {16{8'hC3}};
        i_addr = 32'h0000_2000; d_addr = 32'h0000_3000;
        i_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            observe(12, rd_cnt, wr_cnt, done_at, owner, addr_seen, din_seen);
            check_val($sformatf("cont_owner%0d", t), owner, exp_own[t]);
            check_val($sformatf("cont_done_at%0d", t), done_at, (t == 0) ? 128'd6 : 128'd7);
            check_val($sformatf("cont_addr%0d", t), addr_seen,
                      (exp_own[t] == 2) ? 128'h3000 : 128'h2000);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
`ifdef ARB_DPRIO_EN
        check_val("cont_grants", {i_grants, d_grants}, {12'd0, 12'd4});
        check_val("cont_irdata", i_rdata, 128'd0);
`else
        check_val("cont_grants", {i_grants, d_grants}, {12'd2, 12'd2});
        check_val("cont_irdata", i_rdata, {16{8'hC3}});
`endif
        check_val("cont_drdata", d_rdata, {16{8'hC3}});

        // dcache request dropped mid-access, icache pending
        i_req = 1'b1; i_addr = 32'h0000_0600;
        d_req = 1'b1; d_addr = 32'h0000_0500; data_out_mem = 128'h0F0F;
        extra = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_mem) extra++;
        end
        d_req = 1'b0; d_addr = 32'hFFFF_FFFF;
        observe(10, rd_cnt, wr_cnt, done_at, owner, addr_seen, din_seen);
        check_val("drop_rd_cycles", rd_cnt + extra, 128'd5);
        check_val("drop_done_at", done_at, 128'd4);
        check_val("drop_owner", owner, 128'd2);
        check_val("drop_addr", addr_seen, 128'h500);
        check_val("drop_drdata", d_rdata, 128'h0F0F);
        observe(12, rd_cnt, wr_cnt, done_at, owner, addr_seen, din_seen);
        i_req = 1'b0;
        check_val("pend_owner", owner, 128'd1);
        check_val("pend_done_at", done_at, 128'd7);
        check_val("pend_addr", addr_seen, 128'h600);
        @(negedge clk);

        // Reset in the middle of an icache fill
        i_req = 1'b1; i_addr = 32'h0000_0700;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("mid_rd_active", rd_mem, 128'd1);
        rst = 1'b0;
        #1;
        check_val("mid_rst_ctrl", {i_done, d_done, rd_mem, wr_mem, busy}, 128'd0);
        check_val("mid_rst_addr", addr_mem, 128'd0);
        check_val("mid_rst_rdata", i_rdata | d_rdata, 128'd0);
        check_val("mid_rst_cnt", {i_grants, d_grants}, 128'd0);
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (i_done || busy) pulses++;
        end
        check_val("mid_no_done", pulses, 128'd0);
        check_val("mid_igrants", i_grants, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
